decimal_to_seven_segment: RTL and testbench

- Converts an 8-bit unsigned binary value in the range 0..99 into two decimal digits and drives two 7-segment displays.
- SevenSegment_L shows the tens digit; SevenSegment_R shows the units digit.
- Registered output stage. Sits between the datapath/switch inputs and the board's dual 7-segment display.

---
 rtl/decimal_to_seven_segment.sv | 97 +++++++++
 tb/tb_decimal_to_seven_segment.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/decimal_to_seven_segment.sv
// decimal_to_seven_segment
// Converts an 8-bit binary value (0..99) into tens/units digits and drives two
// registered 7-segment patterns, bit order {a,b,c,d,e,f,g}. Values >= 100
// show a dash on both displays and raise Overflow.
// Optional macro DEC2SEG_LZB_EN: blank the left display when the tens digit is 0.
// SEG_ACTIVE_LOW = 1 inverts every segment bit after encoding, reset included.
module decimal_to_seven_segment #(
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] Decimal,
    output logic [6:0] SevenSegment_L,
    output logic [6:0] SevenSegment_R,
    output logic       Overflow
);

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_DASH  = 7'b0000001;
    localparam logic [6:0] SEG_INV   = {7{SEG_ACTIVE_LOW}};

    // Active-high segment pattern for one decimal digit.
    function automatic logic [6:0] encode_digit(input logic [3:0] digit);
        case (digit)
            4'd0:    encode_digit = 7'b1111110;
            4'd1:    encode_digit = 7'b0110000;
            4'd2:    encode_digit = 7'b1101101;
            4'd3:    encode_digit = 7'b1111001;
            4'd4:    encode_digit = 7'b0110011;
            4'd5:    encode_digit = 7'b1011011;
            4'd6:    encode_digit = 7'b1011111;
            4'd7:    encode_digit = 7'b1110000;
            4'd8:    encode_digit = 7'b1111111;
            4'd9:    encode_digit = 7'b1111011;
            default: encode_digit = SEG_BLANK;
        endcase
    endfunction

    logic [11:0] bcd;
    logic [3:0]  hundreds;
    logic [3:0]  tens;
    logic [3:0]  units;
    logic        out_of_range;
    logic [6:0]  seg_l_next;
    logic [6:0]  seg_r_next;

    // Double dabble: shift the binary value in MSB first, adding 3 to any
    // BCD digit that is 5 or more before each shift.
    always_comb begin
        bcd = '0;
        for (int i = 7; i >= 0; i--) begin
            if (bcd[3:0]  >= 4'd5) bcd[3:0]  = bcd[3:0]  + 4'd3;
            if (bcd[7:4]  >= 4'd5) bcd[7:4]  = bcd[7:4]  + 4'd3;
            if (bcd[11:8] >= 4'd5) bcd[11:8] = bcd[11:8] + 4'd3;
            bcd = {bcd[10:0], Decimal[i]};
        end
    end

    assign hundreds     = bcd[11:8];
    assign tens         = bcd[7:4];
    assign units        = bcd[3:0];
    // The hundreds digit exists only to flag out-of-range inputs.
    assign out_of_range = (hundreds != 4'd0);

    // Select the next segment patterns: dash on overflow, digits otherwise.
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        seg_l_next = SEG_DASH;
        seg_r_next = SEG_DASH;
        if (!out_of_range) begin
            seg_r_next = encode_digit(units);
`ifdef DEC2SEG_LZB_EN
            seg_l_next = (tens == 4'd0) ? SEG_BLANK : encode_digit(tens);
`else
            seg_l_next = encode_digit(tens);
`endif
        end
    end

    // Output register; polarity is applied here so the reset code is
    // inverted together with every other pattern.
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update from values sampled at the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            SevenSegment_L <= SEG_BLANK ^ SEG_INV;
            SevenSegment_R <= SEG_BLANK ^ SEG_INV;
            Overflow       <= 1'b0;
        end else begin
            SevenSegment_L <= seg_l_next ^ SEG_INV;
            SevenSegment_R <= seg_r_next ^ SEG_INV;
            Overflow       <= out_of_range;
        end
    end

endmodule

// File: tb/tb_decimal_to_seven_segment.sv
// Testbench for decimal_to_seven_segment: directed vectors with hand-computed
// segment codes, checked through a scoreboard queue by a separate monitor.
// Two instances run side by side: default polarity and SEG_ACTIVE_LOW = 1.
// Build with +define+DEC2SEG_LZB_EN to check leading-zero blanking.
module tb_decimal_to_seven_segment;

    typedef struct {
        logic [7:0] dec;
        logic [6:0] seg_l;
        logic [6:0] seg_r;
        logic       ovf;
    } exp_t;

    localparam logic [6:0] S0    = 7'b1111110;
    localparam logic [6:0] S1    = 7'b0110000;
    localparam logic [6:0] S2    = 7'b1101101;
    localparam logic [6:0] S3    = 7'b1111001;
    localparam logic [6:0] S4    = 7'b0110011;
    localparam logic [6:0] S5    = 7'b1011011;
    localparam logic [6:0] S6    = 7'b1011111;
    localparam logic [6:0] S7    = 7'b1110000;
    localparam logic [6:0] S8    = 7'b1111111;
    localparam logic [6:0] S9    = 7'b1111011;
    localparam logic [6:0] DASH  = 7'b0000001;
    localparam logic [6:0] BLANK = 7'b0000000;
`ifdef DEC2SEG_LZB_EN
    localparam logic [6:0] TENS0 = BLANK;
`else
    localparam logic [6:0] TENS0 = S0;
`endif

    logic       clk;
    logic       rst_n;
    logic [7:0] Decimal;
    logic [6:0] seg_l;
    logic [6:0] seg_r;
    logic       ovf;
    logic [6:0] seg_l_n;
    logic [6:0] seg_r_n;
    logic       ovf_n;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    decimal_to_seven_segment #(.SEG_ACTIVE_LOW(1'b0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .Decimal        (Decimal),
        .SevenSegment_L (seg_l),
        .SevenSegment_R (seg_r),
        .Overflow       (ovf)
    );

    decimal_to_seven_segment #(.SEG_ACTIVE_LOW(1'b1)) dut_n (
        .clk            (clk),
        .rst_n          (rst_n),
        .Decimal        (Decimal),
        .SevenSegment_L (seg_l_n),
        .SevenSegment_R (seg_r_n),
        .Overflow       (ovf_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    // Drive one vector at the falling edge and queue its expected response.
    task automatic issue(input logic [7:0] dec, input logic [6:0] l,
                         input logic [6:0] r, input logic o);
        exp_t e;
        @(negedge clk);
        Decimal = dec;
        e.dec = dec; e.seg_l = l; e.seg_r = r; e.ovf = o;
        sb.push_back(e);
    endtask

    // Wait for the monitor to consume everything, bounded by a cycle budget.
    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0 pending entries", sb.size());
            sb.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_L"},     seg_l,          BLANK);
        check({tag, "_R"},     seg_r,          BLANK);
        check({tag, "_ovf"},   {6'd0, ovf},    7'd0);
        check({tag, "_L_n"},   seg_l_n,        7'b1111111);
        check({tag, "_R_n"},   seg_r_n,        7'b1111111);
        check({tag, "_ovf_n"}, {6'd0, ovf_n},  7'd0);
    endtask

    // Monitor: one rising edge after each queued sample the outputs are due.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && sb.size() > 0) begin
                e = sb.pop_front();
                check($sformatf("dec%0d_L", e.dec),     seg_l,         e.seg_l);
                check($sformatf("dec%0d_R", e.dec),     seg_r,         e.seg_r);
                check($sformatf("dec%0d_ovf", e.dec),   {6'd0, ovf},   {6'd0, e.ovf});
                check($sformatf("dec%0d_L_n", e.dec),   seg_l_n,       ~e.seg_l);
                check($sformatf("dec%0d_R_n", e.dec),   seg_r_n,       ~e.seg_r);
                check($sformatf("dec%0d_ovf_n", e.dec), {6'd0, ovf_n}, {6'd0, e.ovf});
            end
        end
    end

    // Global watchdog so the run always ends.
    initial begin
        #50000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        Decimal = 8'd57;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst_hold");

        rst_n = 1'b1;
        issue(8'd15,  S1,    S5, 1'b0);
        issue(8'd96,  S9,    S6, 1'b0);
        issue(8'd42,  S4,    S2, 1'b0);
        issue(8'd85,  S8,    S5, 1'b0);
        issue(8'd2,   TENS0, S2, 1'b0);
        issue(8'd0,   TENS0, S0, 1'b0);
        issue(8'd9,   TENS0, S9, 1'b0);
        issue(8'd100, DASH,  DASH, 1'b1);
        issue(8'd255, DASH,  DASH, 1'b1);
        issue(8'd99,  S9,    S9, 1'b0);
        issue(8'd70,  S7,    S0, 1'b0);
        issue(8'd38,  S3,    S8, 1'b0);
        issue(8'd64,  S6,    S4, 1'b0);
        issue(8'd10,  S1,    S0, 1'b0);
        drain();

        // Mid-run asynchronous reset: clears between clock edges.
        @(negedge clk);
        Decimal = 8'd85;
        @(posedge clk);
        #2;
        check("pre_rst_L", seg_l, S8);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_async");
        @(negedge clk);
        check_reset_outputs("rst_async_hold");

        // First conversion after release.
        rst_n = 1'b1;
        issue(8'd15, S1, S5, 1'b0);
        issue(8'd150, DASH, DASH, 1'b1);
        issue(8'd27, S2, S7, 1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
